// File: rtl/sseg_scan_capture.sv
// -----------------------------------------------------------------------------
// sseg_scan_capture
//
// Watches the multiplexed drive lines of a seven-segment display and rebuilds
// the number being shown. Each digit position must hold steady for a few
// cycles before its pattern is decoded and stored into a per-digit slot. Once
// every slot has been captured, the whole frame is published at once together
// with a sign flag and a legality flag. A watchdog raises 'stale' when no
// frame has been published for a long time.
//
// Parameters
//   NUM_DIGITS     number of multiplexed digits (2..8)
//   STABLE_CYCLES  cycles a digit must be held before it is captured (1..255)
//   TIMEOUT_CYCLES cycles without a published frame before 'stale' (>= 2)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   segs          active-low segment pattern, bit 6 = g .. bit 0 = a
//   an            active-low digit enables, an[i] = 0 selects digit i
//   value         published hex digits, digit i in bits [4i+3:4i]
//   neg           published frame carries a minus sign on the top digit
//   valid         every digit of the published frame decoded legally
//   frame_strobe  one-cycle pulse in the cycle value/neg/valid change
//   stale         no frame published within TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module sseg_scan_capture #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                segs,
    input  logic [NUM_DIGITS-1:0]     an,
    output logic [4*NUM_DIGITS-1:0]   value,
    output logic                      neg,
    output logic                      valid,
    output logic                      frame_strobe,
    output logic                      stale
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CW    = $clog2(STABLE_CYCLES + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CW-1:0]    STABLE_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]    CAPTURE_AT = CW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0]    TIMEOUT_AT = TW'(TIMEOUT_CYCLES);

    // Result of decoding one segment pattern.
    typedef struct packed {
        logic [3:0] digit;
        logic       minus;
        logic       legal;
    } dec_t;

    // Maps an active-low segment pattern to a hex digit. Minus and blank are
    // legal and read as 0; anything else is illegal and also reads as 0.
    function automatic dec_t decode(input logic [6:0] s);
        dec_t d;
        d = '{digit: 4'h0, minus: 1'b0, legal: 1'b1};
        case (s)
            7'b1000000: d.digit = 4'h0;
            7'b1111001: d.digit = 4'h1;
            7'b0100100: d.digit = 4'h2;
            7'b0110000: d.digit = 4'h3;
            7'b0011001: d.digit = 4'h4;
            7'b0010010: d.digit = 4'h5;
            7'b0000010: d.digit = 4'h6;
            7'b1111000: d.digit = 4'h7;
            7'b0000000: d.digit = 4'h8;
            7'b0011000: d.digit = 4'h9;
            7'b0001000: d.digit = 4'hA;
            7'b0000011: d.digit = 4'hB;
            7'b1000110: d.digit = 4'hC;
            7'b0100001: d.digit = 4'hD;
            7'b0000110: d.digit = 4'hE;
            7'b0001110: d.digit = 4'hF;
            7'b0111111: d.minus = 1'b1;
            7'b1111111: d.legal = 1'b1;
            default:    d.legal = 1'b0;
        endcase
        return d;
    endfunction

    // Previous-cycle samples used to detect any change on the display lines.
    logic [NUM_DIGITS-1:0] prev_an_q;
    logic [6:0]            prev_segs_q;

    // Dwell counter for the currently selected digit.
    logic [CW-1:0]         stab_q, stab_d;

    // Per-digit capture slots for the frame being assembled.
    logic [3:0]            slot_digit_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] slot_minus_q;
    logic [NUM_DIGITS-1:0] slot_bad_q;
    logic [NUM_DIGITS-1:0] captured_q, captured_d;

    // Published frame.
    logic [4*NUM_DIGITS-1:0] value_q;
    logic                    neg_q;
    logic                    valid_q;
    logic                    strobe_q;

    // Watchdog.
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic                  stale_q, stale_d;

    // Combinational helpers.
    logic                  changed;
    logic                  qualified;
    logic [IDX_W-1:0]      sel_idx;
    logic                  capture;
    logic                  sel_bad;
    logic                  frame_done;
    dec_t                  dec;

    // NOTE: every variable assigned here gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        changed   = (an != prev_an_q) || (segs != prev_segs_q);
        // Exactly one active-low enable must be asserted to trust the sample.
        qualified = ($countones(~an) == 1);

        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) begin
                sel_idx = IDX_W'(i);
            end
        end

        if (changed || !qualified) begin
            stab_d = '0;
        end else if (stab_q < STABLE_MAX) begin
            stab_d = stab_q + 1'b1;
        end else begin
            stab_d = stab_q;
        end

        // Fire only on the edge where the counter arrives at the capture
        // point; saturation above that point guarantees one capture per dwell.
        // The 'changed' term covers STABLE_CYCLES = 1, where the capture point
        // is the cleared value itself.
        capture = qualified && (stab_d == CAPTURE_AT) &&
                  (changed || (stab_q != CAPTURE_AT));

        dec     = decode(segs);
        // A minus sign is only meaningful on the most significant digit.
        sel_bad = !dec.legal || (dec.minus && (sel_idx != LAST_IDX));

        frame_done = &captured_q;

        // Completion empties the frame; a capture on the same edge seeds the
        // next frame.
        captured_d = frame_done ? '0 : captured_q;
        if (capture) begin
            captured_d[sel_idx] = 1'b1;
        end

        if (frame_done) begin
            tcnt_d = '0;
        end else if (tcnt_q < TIMEOUT_AT) begin
            tcnt_d = tcnt_q + 1'b1;
        end else begin
            tcnt_d = tcnt_q;
        end
        // Cleared on the edge that raises frame_strobe, so both are never
        // high together.
        stale_d = !frame_done && (tcnt_d == TIMEOUT_AT);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_an_q    <= '0;
            prev_segs_q  <= '0;
            stab_q       <= '0;
            captured_q   <= '0;
            slot_minus_q <= '0;
            slot_bad_q   <= '0;
            // NOTE: the slot array is reset explicitly so a frame can never
            // publish contents left over from before the reset.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot_digit_q[i] <= '0;
            end
            value_q      <= '0;
            neg_q        <= 1'b0;
            valid_q      <= 1'b0;
            strobe_q     <= 1'b0;
            tcnt_q       <= '0;
            stale_q      <= 1'b0;
        end else begin
            prev_an_q   <= an;
            prev_segs_q <= segs;
            stab_q      <= stab_d;
            captured_q  <= captured_d;
            tcnt_q      <= tcnt_d;
            stale_q     <= stale_d;
            strobe_q    <= frame_done;

            if (capture) begin
                slot_digit_q[sel_idx] <= dec.digit;
                slot_minus_q[sel_idx] <= dec.minus;
                slot_bad_q[sel_idx]   <= sel_bad;
            end

            // Publish reads the slots before any same-edge capture lands.
            if (frame_done) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    value_q[4*i +: 4] <= slot_digit_q[i];
                end
                neg_q   <= slot_minus_q[NUM_DIGITS-1];
                valid_q <= ~|slot_bad_q;
            end
        end
    end

    assign value        = value_q;
    assign neg          = neg_q;
    assign valid        = valid_q;
    assign frame_strobe = strobe_q;
    assign stale        = stale_q;

endmodule
